// File: rtl/fft_mag_unload.sv
// Unloads FFT result bins 0..BINS-1 and streams re^2+im^2 on a valid/ready port.
// Three clock-enabled pipeline stages stall together under backpressure.
`timescale 1ns/1ps
module fft_mag_unload #(
  parameter int unsigned width = 16,
  parameter int unsigned N_2   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [N_2-1:0]       rdadr,
  input  logic [2*width-1:0]   rd,
  output logic [2*width-1:0]   mag,
  output logic [N_2-2:0]       bin,
  output logic                 mag_valid,
  input  logic                 mag_ready,
  output logic                 mag_last,
  output logic                 busy,
  output logic                 unload_done,
  output logic                 overrun
);

  localparam int unsigned W2       = 2 * width;
  localparam int unsigned BINS     = 2 ** (N_2 - 1);
  localparam logic [N_2-1:0] LAST_ADR = N_2'(BINS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [N_2-1:0]   rdadr_q, rdadr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             s1_load;
  logic             adv;

  logic             s1_v_q, s2_v_q, s3_v_q;
  logic [W2-1:0]    s1_rd_q;
  logic [N_2-2:0]   s1_bin_q, s2_bin_q, s3_bin_q;
  logic             s1_last_q, s2_last_q, s3_last_q;
  logic [W2-1:0]    s2_re_sq_q, s2_im_sq_q, s3_mag_q;
  logic signed [W2-1:0] re_x, im_x;

  assign adv = !s3_v_q || mag_ready;

  // Sign-extend components to full product width so each square is exact.
  assign re_x = W2'(signed'(s1_rd_q[W2-1:width]));
  assign im_x = W2'(signed'(s1_rd_q[width-1:0]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rdadr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdadr_q <= rdadr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rdadr_d = rdadr_q;
    ovr_d   = ovr_q;
    done_d  = 1'b0;
    s1_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          rdadr_d = '0;
          ovr_d   = 1'b0;
        end
      end
      RUN: begin
        if (start) ovr_d = 1'b1;
        if (adv) begin
          s1_load = 1'b1;
          if (rdadr_q == LAST_ADR) state_d = DRAIN;
          else                     rdadr_d = rdadr_q + N_2'(1);
        end
      end
      DRAIN: begin
        if (start) ovr_d = 1'b1;
        if (s3_v_q && mag_ready && s3_last_q) begin
          state_d = IDLE;
          rdadr_d = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Datapath: every stage advances only when the output slot is free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s3_v_q     <= 1'b0;
      s1_rd_q    <= '0;
      s1_bin_q   <= '0;
      s2_bin_q   <= '0;
      s3_bin_q   <= '0;
      s1_last_q  <= 1'b0;
      s2_last_q  <= 1'b0;
      s3_last_q  <= 1'b0;
      s2_re_sq_q <= '0;
      s2_im_sq_q <= '0;
      s3_mag_q   <= '0;
    end else if (adv) begin
      s1_v_q <= s1_load;
      if (s1_load) begin
        s1_rd_q   <= rd;
        s1_bin_q  <= rdadr_q[N_2-2:0];
        s1_last_q <= (rdadr_q == LAST_ADR);
      end
      s2_v_q     <= s1_v_q;
      s2_bin_q   <= s1_bin_q;
      s2_last_q  <= s1_last_q;
      s2_re_sq_q <= re_x * re_x;
      s2_im_sq_q <= im_x * im_x;
      s3_v_q     <= s2_v_q;
      s3_bin_q   <= s2_bin_q;
      s3_last_q  <= s2_last_q;
      s3_mag_q   <= s2_re_sq_q + s2_im_sq_q;
    end
  end

  assign rdadr       = rdadr_q;
  assign mag         = s3_mag_q;
  assign bin         = s3_bin_q;
  assign mag_valid   = s3_v_q;
  assign mag_last    = s3_last_q;
  assign busy        = busy_q;
  assign unload_done = done_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_fft_mag_unload.sv
// Scoreboard bench for fft_mag_unload: a RAM model feeds rd, expected beats are
// queued at frame launch and popped as the DUT hands them over.
`timescale 1ns/1ps
module tb_fft_mag_unload;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NL2   = 5;
  localparam int unsigned BINS  = 2 ** (NL2 - 1);

  typedef struct packed {
    logic [3:0]  bin;
    logic [63:0] mag;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  rdadr;
  logic [31:0] rd;
  logic [31:0] mag;
  logic [3:0]  bin;
  logic        mag_valid;
  logic        mag_ready;
  logic        mag_last;
  logic        busy;
  logic        unload_done;
  logic        overrun;

  logic [31:0] ram [0:31];
  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;
  int          rmode  = 0;

  fft_mag_unload #(.width(WIDTH), .N_2(NL2)) dut (
    .clk(clk), .reset(reset), .start(start), .rdadr(rdadr), .rd(rd),
    .mag(mag), .bin(bin), .mag_valid(mag_valid), .mag_ready(mag_ready),
    .mag_last(mag_last), .busy(busy), .unload_done(unload_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;
  assign rd = ram[rdadr];

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Ready pattern generator: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  initial begin
    int pcnt;
    pcnt = 0;
    mag_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1: begin
          mag_ready = (pcnt == 0) || (pcnt == 3);
          pcnt = (pcnt + 1) % 4;
        end
        2: mag_ready = ($urandom_range(0, 2) != 0);
        default: mag_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: scoreboard pops, hold stability, unload_done timing, rdadr sanity.
  initial begin
    logic        hold_prev, pend_done, prev_busy;
    logic [31:0] pmag;
    logic [3:0]  pbin;
    logic        plast;
    logic [4:0]  prdadr;
    exp_t        e;
    hold_prev = 0; pend_done = 0; prev_busy = 0;
    pmag = '0; pbin = '0; plast = 0; prdadr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_prev = 0; pend_done = 0; prev_busy = 0;
      end else begin
        chk("unload_done", longint'(unload_done), longint'(pend_done));
        pend_done = mag_valid && mag_ready && mag_last;
        if (busy) chk("rdadr_range", longint'(rdadr <= 5'(BINS - 1)), 1);
        if (prev_busy && busy)
          chk("rdadr_step", longint'((rdadr == prdadr) || (rdadr == prdadr + 5'd1)), 1);
        if (hold_prev) begin
          chk("hold_valid", longint'(mag_valid), 1);
          chk("hold_mag", longint'(mag), longint'(pmag));
          chk("hold_bin", longint'(bin), longint'(pbin));
          chk("hold_last", longint'(mag_last), longint'(plast));
        end
        if (mag_valid && mag_ready) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("bin", longint'(bin), longint'(e.bin));
            chk("mag", longint'(mag), longint'(e.mag));
            chk("last", longint'(mag_last), longint'(e.last));
          end
        end
        hold_prev = mag_valid && !mag_ready;
        pmag = mag; pbin = bin; plast = mag_last;
        prdadr = rdadr; prev_busy = busy;
      end
    end
  end

  task automatic push_frame();
    exp_t   e;
    longint re, im;
    for (int k = 0; k < int'(BINS); k++) begin
      re = longint'($signed(ram[k][31:16]));
      im = longint'($signed(ram[k][15:0]));
      e.bin  = 4'(k);
      e.mag  = 64'(re * re + im * im);
      e.last = (k == int'(BINS) - 1);
      sb.push_back(e);
    end
  endtask

  task automatic fill_basic();
    for (int k = 0; k < 32; k++)
      ram[k] = (k < int'(BINS)) ? {16'(k), 16'(-k)} : 32'hDEAD_BEEF;
  endtask

  // Queue expectations and pulse start; returns 1 ns after the start edge.
  task automatic launch();
    push_frame();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic lat_check(input string tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({tag, "_early_valid"}, longint'(mag_valid), 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_first_valid"}, longint'(mag_valid), 1);
    chk({tag, "_first_bin"}, longint'(bin), 0);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (unload_done) begin
        seen = 1;
        break;
      end
    end
    chk({tag, "_done_seen"}, longint'(seen), 1);
    chk({tag, "_sb_empty"}, longint'(sb.size()), 0);
  endtask

  task automatic wait_bin(input int b, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mag_valid && bin == 4'(b)) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    reset = 1'b1;
    start = 1'b0;
    fill_basic();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mag", longint'(mag), 0);
    chk("rst_bin", longint'(bin), 0);
    chk("rst_valid", longint'(mag_valid), 0);
    chk("rst_last", longint'(mag_last), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(unload_done), 0);
    chk("rst_overrun", longint'(overrun), 0);
    chk("rst_rdadr", longint'(rdadr), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Basic ramp with latency check
    launch();
    chk("basic_busy", longint'(busy), 1);
    lat_check("basic");
    wait_done("basic");

    // Extreme component values
    ram[0] = {16'h8000, 16'h8000};
    ram[1] = {16'h7FFF, 16'h0000};
    ram[2] = {16'h0000, 16'h8000};
    launch();
    wait_done("extreme");
    fill_basic();

    // Backpressure: fixed pattern then random
    rmode = 1;
    launch();
    wait_done("bp_pattern");
    rmode = 2;
    launch();
    wait_done("bp_random");
    rmode = 0;
    @(posedge clk);

    // Start while busy
    launch();
    wait_bin(5, ok);
    chk("ovr_reach_bin5", longint'(ok), 1);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("ovr_set", longint'(overrun), 1);
    wait_done("ovr");
    chk("ovr_sticky", longint'(overrun), 1);
    launch();
    chk("ovr_cleared", longint'(overrun), 0);
    wait_done("ovr_next");

    // Asynchronous reset mid-run
    launch();
    wait_bin(7, ok);
    chk("rst_reach_bin7", longint'(ok), 1);
    #2 reset = 1'b1;
    #1;
    chk("mrst_valid", longint'(mag_valid), 0);
    chk("mrst_mag", longint'(mag), 0);
    chk("mrst_bin", longint'(bin), 0);
    chk("mrst_last", longint'(mag_last), 0);
    chk("mrst_busy", longint'(busy), 0);
    chk("mrst_rdadr", longint'(rdadr), 0);
    chk("mrst_done", longint'(unload_done), 0);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    launch();
    lat_check("post_rst");
    wait_done("post_rst");

    // Back-to-back: start raised during the unload_done cycle
    launch();
    wait_done("b2b_first");
    push_frame();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b_busy", longint'(busy), 1);
    lat_check("b2b");
    wait_done("b2b_second");
    chk("b2b_overrun", longint'(overrun), 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
